// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//   Round-robin write arbiter in front of a shared WIDTH-bit register that is
//   kept as a q / q_not pair. One requester wins per cycle. The winner's data
//   is loaded and a one-cycle registered grant is returned. Completed writes
//   are counted in wr_count.
//
//   Optional feature macro: REG_ARB_LOCK_EN
//     When it is defined, the lock port and the LOCK state are present. A
//     winner that holds lock keeps exclusive write access, one write per
//     cycle, until it drops lock or req.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   req       in   [N_REQ]        write request per requester
//   wdata     in   [N_REQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   lock      in   [N_REQ]        burst-lock request (REG_ARB_LOCK_EN only)
//   gnt       out  [N_REQ]        registered one-hot write acknowledge
//   q         out  [WIDTH]        shared register contents
//   q_not     out  [WIDTH]        registered bitwise complement of q
//   busy      out                 any req pending or arbiter locked (comb)
//   wr_count  out  [CNT_W]        completed writes, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] wdata,
`ifdef REG_ARB_LOCK_EN
   input  logic [N_REQ-1:0]       lock,
`endif
   output logic [N_REQ-1:0]       gnt,
   output logic [WIDTH-1:0]       q,
   output logic [WIDTH-1:0]       q_not,
   output logic                   busy,
   output logic [CNT_W-1:0]       wr_count
);

   localparam int unsigned PTR_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_LOCK  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   q_not_q, q_not_d;
   logic [CNT_W-1:0]   wr_count_q, wr_count_d;
`ifdef REG_ARB_LOCK_EN
   logic [PTR_W-1:0]   owner_q, owner_d;
`endif

   logic [WIDTH-1:0]   data_arr [N_REQ];
   logic [N_REQ-1:0]   elig;
   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   int unsigned        cand;

   // Wrap-around increment of a requester index.
   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
      return (32'(p) == N_REQ - 1) ? '0 : p + PTR_W'(1);
   endfunction

   // Unpack the flat data bus into one word per requester.
   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign data_arr[i] = wdata[i*WIDTH +: WIDTH];
   end

   // The requester acknowledged this cycle is masked so a held req is not rewritten.
   assign elig = req & ~gnt_q;

   // Round-robin search starting at ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!win_found && elig[PTR_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(cand);
         end
      end
   end

   // Next-state and register-load logic.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = '0;
      q_d        = q_q;
      q_not_d    = q_not_q;
      wr_count_d = wr_count_q;
`ifdef REG_ARB_LOCK_EN
      owner_d    = owner_q;

      if (state_q == ST_LOCK) begin
         // Owner writes every cycle; the gnt mask does not apply here.
         if (lock[owner_q] && req[owner_q]) begin
            gnt_d      = N_REQ'(1) << owner_q;
            q_d        = data_arr[owner_q];
            q_not_d    = ~data_arr[owner_q];
            wr_count_d = wr_count_q + CNT_W'(1);
         end else begin
            state_d = ST_IDLE;
            ptr_d   = inc_ptr(owner_q);
         end
      end else
`endif
      begin
         if (win_found) begin
            state_d    = ST_GRANT;
            gnt_d      = N_REQ'(1) << win_idx;
            q_d        = data_arr[win_idx];
            q_not_d    = ~data_arr[win_idx];
            wr_count_d = wr_count_q + CNT_W'(1);
            ptr_d      = inc_ptr(win_idx);
`ifdef REG_ARB_LOCK_EN
            if (lock[win_idx]) begin
               state_d = ST_LOCK;
               owner_d = win_idx;
            end
`endif
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         gnt_q      <= '0;
         q_q        <= '0;
         q_not_q    <= '1;
         wr_count_q <= '0;
`ifdef REG_ARB_LOCK_EN
         owner_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         q_q        <= q_d;
         q_not_q    <= q_not_d;
         wr_count_q <= wr_count_d;
`ifdef REG_ARB_LOCK_EN
         owner_q    <= owner_d;
`endif
      end
   end

   assign gnt      = gnt_q;
   assign q        = q_q;
   assign q_not    = q_not_q;
   assign wr_count = wr_count_q;

`ifdef REG_ARB_LOCK_EN
   assign busy = (|req) | (state_q == ST_LOCK);
`else
   assign busy = |req;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//   Directed bench for reg_write_arbiter (N_REQ=4, WIDTH=8, CNT_W=4 so that
//   the counter wrap is reachable). The lock scenario is built only when
//   REG_ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] wdata;
`ifdef REG_ARB_LOCK_EN
   logic [N_REQ-1:0]       lock;
`endif
   logic [N_REQ-1:0]       gnt;
   logic [WIDTH-1:0]       q;
   logic [WIDTH-1:0]       q_not;
   logic                   busy;
   logic [CNT_W-1:0]       wr_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_write_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .wdata    (wdata),
`ifdef REG_ARB_LOCK_EN
      .lock     (lock),
`endif
      .gnt      (gnt),
      .q        (q),
      .q_not    (q_not),
      .busy     (busy),
      .wr_count (wr_count)
   );

   // Advance to just after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Synchronous-looking reset pulse between falling edges; inputs idle.
   task automatic apply_reset;
      req   = '0;
      wdata = '0;
`ifdef REG_ARB_LOCK_EN
      lock  = '0;
`endif
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      req   = '0;
      wdata = '0;
`ifdef REG_ARB_LOCK_EN
      lock  = '0;
`endif
      #2;
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", q); end
      checks++; if (q_not !== 8'hFF) begin errors++; $display("FAIL reset_q_not: got %h expected ff", q_not); end
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_two_req;
      apply_reset();
      wdata[0*WIDTH +: WIDTH] = 8'h11;
      wdata[2*WIDTH +: WIDTH] = 8'h22;
      req = 4'b0101;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL two_busy: got %b expected 1", busy); end
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL two_gnt0: got %b expected 0001", gnt); end
      checks++; if (q !== 8'h11) begin errors++; $display("FAIL two_q0: got %h expected 11", q); end
      req = 4'b0100;
      tick();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL two_gnt2: got %b expected 0100", gnt); end
      checks++; if (q !== 8'h22) begin errors++; $display("FAIL two_q2: got %h expected 22", q); end
      checks++; if (q_not !== 8'hDD) begin errors++; $display("FAIL two_q_not2: got %h expected dd", q_not); end
      req = 4'b0000;
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL two_gnt_idle: got %b expected 0000", gnt); end
      checks++; if (q !== 8'h22) begin errors++; $display("FAIL two_q_hold: got %h expected 22", q); end
      checks++; if (wr_count !== 4'd2) begin errors++; $display("FAIL two_wr_count: got %0d expected 2", wr_count); end
   endtask

   task automatic test_all_req;
      logic [3:0] exp_g [5];
      logic [7:0] exp_q [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_q = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
      apply_reset();
      wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      req   = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL all_gnt[%0d]: got %b expected %b", i, gnt, exp_g[i]); end
         checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL all_q[%0d]: got %h expected %h", i, q, exp_q[i]); end
      end
      checks++; if (wr_count !== 4'd5) begin errors++; $display("FAIL all_wr_count: got %0d expected 5", wr_count); end
      req = '0;
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL all_gnt_idle: got %b expected 0000", gnt); end
   endtask

   task automatic test_single;
      logic [3:0] exp_g [6];
      logic [7:0] exp_q [6];
      logic [7:0] nxt   [3];
      int         n;
      exp_g = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
      exp_q = '{8'h5A, 8'h5A, 8'h3C, 8'h3C, 8'hC3, 8'hC3};
      nxt   = '{8'h3C, 8'hC3, 8'hC3};
      n = 0;
      apply_reset();
      wdata[1*WIDTH +: WIDTH] = 8'h5A;
      req = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL single_gnt[%0d]: got %b expected %b", i, gnt, exp_g[i]); end
         checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL single_q[%0d]: got %h expected %h", i, q, exp_q[i]); end
         checks++; if (q_not !== ~exp_q[i]) begin errors++; $display("FAIL single_q_not[%0d]: got %h expected %h", i, q_not, ~exp_q[i]); end
         if (exp_g[i] != 4'b0000) begin
            wdata[1*WIDTH +: WIDTH] = nxt[n];
            n++;
         end
      end
      checks++; if (wr_count !== 4'd3) begin errors++; $display("FAIL single_wr_count: got %0d expected 3", wr_count); end
      req = '0;
   endtask

   task automatic test_wrap;
      apply_reset();
      wdata = {8'h00, 8'h00, 8'h66, 8'h55};
      req   = 4'b0011;
      for (int i = 1; i <= 16; i++) begin
         tick();
         checks++; if (wr_count !== 4'(i)) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, wr_count, 4'(i)); end
      end
      checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", wr_count); end
      req = '0;
      tick();
      checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL wrap_hold: got %0d expected 0", wr_count); end
   endtask

   task automatic test_reset_mid;
      apply_reset();
      wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      req   = 4'b1111;
      tick();
      tick();
      checks++; if (q !== 8'h22) begin errors++; $display("FAIL mid_pre_q: got %h expected 22", q); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_q: got %h expected 00", q); end
      checks++; if (q_not !== 8'hFF) begin errors++; $display("FAIL mid_q_not: got %h expected ff", q_not); end
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt: got %b expected 0000", gnt); end
      checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL mid_wr_count: got %0d expected 0", wr_count); end
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_held_gnt: got %b expected 0000", gnt); end
      @(negedge clk);
      reset = 1'b0;
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_restart_gnt: got %b expected 0001", gnt); end
      req = '0;
   endtask

`ifdef REG_ARB_LOCK_EN
   task automatic test_lock;
      apply_reset();
      wdata = {8'h88, 8'h00, 8'h00, 8'h77};
      req   = 4'b1001;
      lock  = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL lock_gnt[%0d]: got %b expected 0001", i, gnt); end
         checks++; if (q !== 8'h77) begin errors++; $display("FAIL lock_q[%0d]: got %h expected 77", i, q); end
      end
      lock = 4'b0000;
      req  = 4'b1000;
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL lock_exit_gnt: got %b expected 0000", gnt); end
      tick();
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL lock_after_gnt: got %b expected 1000", gnt); end
      checks++; if (q !== 8'h88) begin errors++; $display("FAIL lock_after_q: got %h expected 88", q); end
      checks++; if (wr_count !== 4'd4) begin errors++; $display("FAIL lock_wr_count: got %0d expected 4", wr_count); end
      req = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_two_req();
      test_all_req();
      test_single();
      test_wrap();
      test_reset_mid();
`ifdef REG_ARB_LOCK_EN
      test_lock();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
